// File: rtl/clock_stage_decoder_pkg.sv
// clock_stage_decoder_pkg: shared stage/state/error types for the stage-clock receiver.
package clock_stage_decoder_pkg;

    localparam int NUM_STAGES = 4;

    typedef enum logic [1:0] {STAGE0, STAGE1, STAGE2, STAGE3} stage_e;
    typedef enum logic {UNLOCKED, LOCKED} state_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_ONEHOT, ERR_MISMATCH, ERR_ORDER} err_e;

    // Index of a one-hot rise vector; meaningless if not one-hot.
    function automatic logic [1:0] rise_index(logic [NUM_STAGES-1:0] rise);
        return {rise[3] | rise[2], rise[3] | rise[1]};
    endfunction

    // Highest-priority protocol error for a nonzero rise vector.
    function automatic err_e classify(logic [NUM_STAGES-1:0] rise, stage_e stage, stage_e expected);
        logic [1:0] idx;
        idx = rise_index(rise);
        return ((rise & (rise - 4'd1)) != 4'd0) ? ERR_ONEHOT :
               (stage != idx)                   ? ERR_MISMATCH :
               (expected != idx)                ? ERR_ORDER : ERR_NONE;
    endfunction

endpackage

// File: rtl/clock_stage_decoder_sync_chain.sv
// sync_chain: WIDTH-bit multi-flop synchroniser, DEPTH flops deep, cleared by reset.
module sync_chain #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= '{default: '0};
        end else begin
            chain[0] <= d;
            for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/clock_stage_decoder.sv
// clock_stage_decoder: tracks 4-phase stage strobes, emits stage/instruction pulses
// and sticky protocol-error flags, relocking on the next clean phase-0 edge.
module clock_stage_decoder
    import clock_stage_decoder_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ICOUNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          phase_in,
    input  logic [1:0]          stage_in,
    input  logic                clear_err,
    output logic [3:0]          stage_en,
    output logic [1:0]          cur_stage,
    output logic                locked,
    output logic                instr_done,
    output logic [ICOUNT_W-1:0] instr_count,
    output logic                err_order,
    output logic                err_onehot,
    output logic                err_mismatch,
    output logic                err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [3:0]      phase_s, phase_prev, rise;
    logic [1:0]      stage_s, idx;
    logic [WD_W-1:0] wd;
    state_e          state, state_next;
    stage_e          expected, expected_next;
    err_e            err, bad;
    logic            lock_ok, valid, timeout;

    sync_chain #(.WIDTH(4), .DEPTH(SYNC_STAGES)) u_phase_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (phase_in),
        .q     (phase_s)
    );

    sync_chain #(.WIDTH(2), .DEPTH(SYNC_STAGES)) u_stage_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (stage_in),
        .q     (stage_s)
    );

    assign rise   = phase_s & ~phase_prev;
    assign locked = state == LOCKED;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= UNLOCKED;
            expected <= STAGE0;
        end else begin
            state    <= state_next;
            expected <= expected_next;
        end
    end

    always_comb begin
        state_next    = state == UNLOCKED ? (lock_ok ? LOCKED : UNLOCKED) :
                        (timeout || bad != ERR_NONE) ? UNLOCKED : LOCKED;
        expected_next = valid ? stage_e'(idx + 2'd1) :
                        state_next == UNLOCKED ? STAGE0 : expected;
    end

    always_comb begin
        idx     = rise_index(rise);
        err     = classify(rise, stage_e'(stage_s), expected);
        lock_ok = rise == 4'b0001 && stage_s == 2'd0;
        bad     = (state == LOCKED && rise != 4'd0) ? err : ERR_NONE;
        valid   = state == LOCKED ? (rise != 4'd0 && err == ERR_NONE) : lock_ok;
        timeout = state == LOCKED && rise == 4'd0 && wd == WD_W'(TIMEOUT_CYCLES - 1);
    end

    // New errors are OR-ed in after the clear so they survive a simultaneous clear_err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_prev   <= '0;
            stage_en     <= '0;
            instr_done   <= 1'b0;
            cur_stage    <= '0;
            instr_count  <= '0;
            wd           <= '0;
            err_order    <= 1'b0;
            err_onehot   <= 1'b0;
            err_mismatch <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            phase_prev   <= phase_s;
            stage_en     <= valid ? rise : 4'd0;
            instr_done   <= valid && rise[3];
            cur_stage    <= valid ? idx : cur_stage;
            instr_count  <= (valid && rise[3]) ? instr_count + 1'b1 : instr_count;
            wd           <= (state == LOCKED && rise == 4'd0 && !timeout) ? wd + 1'b1 : '0;
            err_order    <= (err_order & ~clear_err) | (bad == ERR_ORDER);
            err_onehot   <= (err_onehot & ~clear_err) | (bad == ERR_ONEHOT);
            err_mismatch <= (err_mismatch & ~clear_err) | (bad == ERR_MISMATCH);
            err_timeout  <= (err_timeout & ~clear_err) | timeout;
        end
    end

endmodule

// File: tb/tb_clock_stage_decoder.sv
// tb_clock_stage_decoder: directed strobe sequences; expected pulses are queued on
// issue and a negedge monitor pops and compares each pulse the DUT presents.
module tb_clock_stage_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] phase_in = '0;
    logic [1:0] stage_in = '0;
    logic       clear_err = 1'b0;
    logic [3:0] stage_en;
    logic [1:0] cur_stage;
    logic       locked, instr_done;
    logic [3:0] instr_count;
    logic       err_order, err_onehot, err_mismatch, err_timeout;

    typedef struct {
        int         cyc;
        logic [3:0] en;
        logic       done;
        logic [1:0] stage;
        logic [3:0] cnt;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [3:0] exp_cnt = '0;

    clock_stage_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(64), .ICOUNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .phase_in     (phase_in),
        .stage_in     (stage_in),
        .clear_err    (clear_err),
        .stage_en     (stage_en),
        .cur_stage    (cur_stage),
        .locked       (locked),
        .instr_done   (instr_done),
        .instr_count  (instr_count),
        .err_order    (err_order),
        .err_onehot   (err_onehot),
        .err_mismatch (err_mismatch),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (stage_en !== 4'd0 || instr_done !== 1'b0) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {27'd0, instr_done, stage_en}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("stage_en", stage_en, e.en);
                chk("instr_done", instr_done, e.done);
                chk("cur_stage", cur_stage, e.stage);
                chk("instr_count", instr_count, e.cnt);
                chk("locked_on_pulse", locked, 1);
            end
        end
    end

    // Strobe mask for 4 clocks; ok=1 queues the expected pulse 3 clocks after the rise.
    task automatic strobe(input logic [3:0] mask, input logic [1:0] stg, input bit ok, input bit clr = 0);
        exp_t e;
        @(negedge clk);
        phase_in = mask;
        stage_in = stg;
        if (ok) begin
            e.cyc   = cyc + 3;
            e.en    = mask;
            e.done  = mask[3];
            e.stage = mask[3] ? 2'd3 : mask[2] ? 2'd2 : mask[1] ? 2'd1 : 2'd0;
            if (mask[3]) exp_cnt = exp_cnt + 4'd1;
            e.cnt   = exp_cnt;
            q.push_back(e);
        end
        repeat (2) @(negedge clk);
        clear_err = clr;
        @(negedge clk);
        clear_err = 1'b0;
        @(negedge clk);
        phase_in = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic sequence4();
        for (int k = 0; k < 4; k++) strobe(4'(1 << k), 2'(k), 1);
    endtask

    task automatic clr();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        phase_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stage_en"}, stage_en, 0);
        chk({tag, "_cur_stage"}, cur_stage, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_count"}, instr_count, 0);
        chk({tag, "_errs"}, {err_order, err_onehot, err_mismatch, err_timeout}, 0);
    endtask

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        repeat (3) sequence4();
        chk("seq_locked", locked, 1);
        chk("seq_count", instr_count, 3);
        chk("seq_errs", {err_order, err_onehot, err_mismatch, err_timeout}, 0);

        strobe(4'b0001, 2'd0, 1);
        strobe(4'b0100, 2'd2, 0);
        chk("order_flag", err_order, 1);
        chk("order_unlocked", locked, 0);
        strobe(4'b0001, 2'd0, 1);
        chk("relock", locked, 1);
        chk("order_sticky", err_order, 1);
        clr();
        chk("order_cleared", err_order, 0);

        strobe(4'b0110, 2'd1, 0);
        chk("onehot_flag", err_onehot, 1);
        chk("onehot_no_mismatch", err_mismatch, 0);
        chk("onehot_no_order", err_order, 0);
        chk("onehot_unlocked", locked, 0);
        clr();

        strobe(4'b0001, 2'd0, 1);
        strobe(4'b0010, 2'd2, 0);
        chk("mismatch_flag", err_mismatch, 1);
        chk("mismatch_unlocked", locked, 0);
        clr();
        chk("mismatch_cleared", err_mismatch, 0);
        strobe(4'b0001, 2'd0, 1);
        strobe(4'b0010, 2'd2, 0, 1);
        chk("mismatch_beats_clear", err_mismatch, 1);
        clr();

        @(negedge clk);
        phase_in = 4'b0001;
        stage_in = 2'd0;
        c0 = cyc;
        q.push_back('{cyc: c0 + 3, en: 4'b0001, done: 1'b0, stage: 2'd0, cnt: exp_cnt});
        repeat (4) @(negedge clk);
        phase_in = '0;
        while (cyc < c0 + 66) @(negedge clk);
        chk("timeout_early", err_timeout, 0);
        chk("timeout_still_locked", locked, 1);
        @(negedge clk);
        chk("timeout_flag", err_timeout, 1);
        chk("timeout_unlocked", locked, 0);
        clr();
        repeat (100) @(negedge clk);
        chk("no_timeout_unlocked", err_timeout, 0);

        do_reset();
        repeat (17) sequence4();
        chk("wrap_count", instr_count, 1);

        strobe(4'b0001, 2'd0, 1);
        strobe(4'b0010, 2'd1, 1);
        @(negedge clk);
        phase_in = 4'b0100;
        stage_in = 2'd2;
        @(negedge clk);
        rst_n = 1'b0;
        phase_in = '0;
        @(negedge clk);
        chk_all_zero("midreset");
        rst_n = 1'b1;
        exp_cnt = '0;
        strobe(4'b1000, 2'd3, 0);
        chk("post_reset_ignored", locked, 0);
        chk("post_reset_no_err", {err_order, err_onehot, err_mismatch, err_timeout}, 0);
        strobe(4'b0001, 2'd0, 1);
        chk("post_reset_relock", locked, 1);

        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
